// File: rtl/serial_word_tx_if.sv
// Word handshake between a producing datapath (master) and serial_word_tx (slave).
interface serial_word_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;

    modport master (output data_i, output valid_i, input  ready_o);
    modport slave  (input  data_i, input  valid_i, output ready_o);
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter: accepts a word on a valid/ready handshake and
// shifts it out one bit per clock with frame and end-of-word qualifiers.
module serial_word_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_word_tx_if.slave      bus,
    output logic                 serial_o,
    output logic                 frame_o,
    output logic                 done_o
);
    localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit ONE_BIT = (WIDTH == 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             serial_nxt, frame_nxt, done_nxt;
    logic             ready, accept;
    logic [WIDTH-1:0] word;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign word = bus.data_i;

    // cnt counts the bits still to follow the one on serial_o, so cnt==0 marks
    // the final bit and lets the next word load on that same edge.
    assign ready       = rst_n && ((state == IDLE) || (cnt == '0));
    assign bus.ready_o = ready;
    assign accept      = bus.valid_i && ready;

    always_comb begin
        state_nxt  = state;
        sh_nxt     = sh;
        cnt_nxt    = cnt;
        serial_nxt = 1'b0;
        frame_nxt  = 1'b0;
        done_nxt   = 1'b0;

        if (accept) begin
            state_nxt  = SHIFT;
            sh_nxt     = word;
            cnt_nxt    = CNT_W'(WIDTH - 1);
            frame_nxt  = 1'b1;
            serial_nxt = out_bit(word);
            done_nxt   = ONE_BIT;
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                sh_nxt     = shift_word(sh);
                cnt_nxt    = cnt - 1'b1;
                frame_nxt  = 1'b1;
                serial_nxt = out_bit(sh_nxt);
                done_nxt   = (cnt == CNT_W'(1));
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            serial_o <= 1'b0;
            frame_o  <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sh       <= sh_nxt;
            cnt      <= cnt_nxt;
            serial_o <= serial_nxt;
            frame_o  <= frame_nxt;
            done_o   <= done_nxt;
        end
    end
endmodule
